// File: rtl/mod_n_chain_counter_if.sv
// Control and value bundle for the cascadable modulo-N counter.
// Ports: x/dir/load/d into the counter; bits/q out of it.
interface mod_n_chain_counter_if #(
  parameter int DIGITS = 2,
  parameter int W      = 4
);
  logic              x;
  logic              dir;
  logic              load;
  logic [DIGITS*W-1:0] d;
  logic [DIGITS*W-1:0] bits;
  logic              q;

  modport master (
    output x, dir, load, d,
    input  bits, q
  );

  modport slave (
    input  x, dir, load, d,
    output bits, q
  );
endinterface

// File: rtl/mod_n_chain_counter.sv
// Cascaded up/down modulo-MOD counter with parallel load and an
// optional edge-qualified count input. Ports: cp, reset (sync, low),
// bus.slave (x, dir, load, d in; bits value, q terminal pulse out).
module mod_n_chain_counter #(
  parameter int DIGITS = 2,
  parameter int MOD    = 10,
  parameter int W      = 4,
  parameter int EDGE   = 0
) (
  input logic                  cp,
  input logic                  reset,
  mod_n_chain_counter_if.slave bus
);

  localparam logic [W-1:0] TOP = W'(MOD - 1);

  logic [DIGITS*W-1:0] cnt_q, cnt_d;
  logic                q_q, q_d;
  logic                xd_q;
  logic                step;
  logic                run;
  logic                term;
  logic [W-1:0]        dig;
  logic [W-1:0]        ld;

  assign step = (EDGE != 0) ? (bus.x & ~xd_q) : bus.x;

  // run ripples through the digits: a digit moves only when the
  // step is active and every lower digit sits at its terminal value.
  always_comb begin
    cnt_d = cnt_q;
    q_d   = 1'b0;
    run   = step;
    term  = 1'b0;
    dig   = '0;
    ld    = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dig  = cnt_q[i*W +: W];
      term = bus.dir ? (dig == TOP) : (dig == '0);
      if (bus.load) begin
        ld = bus.d[i*W +: W];
        cnt_d[i*W +: W] = (ld > TOP) ? TOP : ld;
      end else if (run) begin
        if (term)
          cnt_d[i*W +: W] = bus.dir ? '0 : TOP;
        else
          cnt_d[i*W +: W] = bus.dir ? dig + W'(1)
                                    : dig - W'(1);
      end
      run = run & term;
    end
    q_d = ~bus.load & run;
  end

  always_ff @(posedge cp) begin
    if (!reset) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
      xd_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
      xd_q  <= bus.x;
    end
  end

  assign bus.bits = cnt_q;
  assign bus.q    = q_q;

endmodule

// File: tb/tb_mod_n_chain_counter.sv
// Directed bench for mod_n_chain_counter: one level-count and one
// edge-count instance, DIGITS=2, MOD=10, W=4.
module tb_mod_n_chain_counter;

  logic cp;
  logic reset;
  int   checks;
  int   errors;

  mod_n_chain_counter_if #(.DIGITS(2), .W(4)) if0 ();
  mod_n_chain_counter_if #(.DIGITS(2), .W(4)) if1 ();

  mod_n_chain_counter #(
    .DIGITS(2), .MOD(10), .W(4), .EDGE(0)
  ) u0 (
    .cp(cp), .reset(reset), .bus(if0.slave)
  );

  mod_n_chain_counter #(
    .DIGITS(2), .MOD(10), .W(4), .EDGE(1)
  ) u1 (
    .cp(cp), .reset(reset), .bus(if1.slave)
  );

  initial cp = 1'b0;
  always #10 cp = ~cp;

  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    if0.x = 1'b1; if0.load = 1'b1;
    if0.d = 8'h55; if0.dir = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (if0.bits !== 8'h00) begin
        errors++;
        $display("FAIL rst_bits cyc%0d got=%h exp=00",
                 i, if0.bits);
      end
      checks++;
      if (if0.q !== 1'b0) begin
        errors++;
        $display("FAIL rst_q cyc%0d got=%b exp=0", i, if0.q);
      end
    end
    reset = 1'b1;
    if0.load = 1'b0;
    tick();
    checks++;
    if (if0.bits !== 8'h01) begin
      errors++;
      $display("FAIL rst_first got=%h exp=01", if0.bits);
    end
    checks++;
    if (if1.bits !== 8'h00) begin
      errors++;
      $display("FAIL rst_edge_idle got=%h exp=00", if1.bits);
    end
    if0.x = 1'b0;
  endtask

  task automatic test_up_wrap();
    if0.load = 1'b1; if0.d = 8'h98;
    if0.x = 1'b0; if0.dir = 1'b1;
    tick();
    checks++;
    if (if0.bits !== 8'h98) begin
      errors++;
      $display("FAIL up_load got=%h exp=98", if0.bits);
    end
    if0.load = 1'b0; if0.x = 1'b1;
    tick();
    checks++;
    if (if0.bits !== 8'h99 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL up_99 got=%h q=%b exp=99 q=0",
               if0.bits, if0.q);
    end
    tick();
    checks++;
    if (if0.bits !== 8'h00 || if0.q !== 1'b1) begin
      errors++;
      $display("FAIL up_wrap got=%h q=%b exp=00 q=1",
               if0.bits, if0.q);
    end
    if0.x = 1'b0;
    tick();
    checks++;
    if (if0.bits !== 8'h00 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL up_after got=%h q=%b exp=00 q=0",
               if0.bits, if0.q);
    end
  endtask

  task automatic test_down_wrap();
    if0.load = 1'b1; if0.d = 8'h01; if0.x = 1'b0;
    tick();
    if0.load = 1'b0; if0.dir = 1'b0; if0.x = 1'b1;
    tick();
    checks++;
    if (if0.bits !== 8'h00 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL dn_00 got=%h q=%b exp=00 q=0",
               if0.bits, if0.q);
    end
    tick();
    checks++;
    if (if0.bits !== 8'h99 || if0.q !== 1'b1) begin
      errors++;
      $display("FAIL dn_wrap got=%h q=%b exp=99 q=1",
               if0.bits, if0.q);
    end
    if0.load = 1'b1; if0.d = 8'h09; if0.x = 1'b0;
    tick();
    if0.load = 1'b0; if0.x = 1'b1;
    tick();
    checks++;
    if (if0.bits !== 8'h08 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL dn_08 got=%h q=%b exp=08 q=0",
               if0.bits, if0.q);
    end
    if0.x = 1'b0; if0.dir = 1'b1;
  endtask

  task automatic test_edge();
    int pat [8];
    pat = '{1, 1, 1, 1, 1, 0, 0, 1};
    if1.dir = 1'b1; if1.load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if1.x = pat[i][0];
      tick();
      if (i == 0) begin
        checks++;
        if (if1.bits !== 8'h01) begin
          errors++;
          $display("FAIL edge_first got=%h exp=01", if1.bits);
        end
      end
      if (i == 4) begin
        checks++;
        if (if1.bits !== 8'h01) begin
          errors++;
          $display("FAIL edge_held got=%h exp=01", if1.bits);
        end
      end
    end
    if1.x = 1'b0;
    tick();
    checks++;
    if (if1.bits !== 8'h02 || if1.q !== 1'b0) begin
      errors++;
      $display("FAIL edge_count got=%h q=%b exp=02 q=0",
               if1.bits, if1.q);
    end
    if1.load = 1'b1; if1.d = 8'h37; if1.x = 1'b1;
    tick();
    checks++;
    if (if1.bits !== 8'h37) begin
      errors++;
      $display("FAIL edge_load got=%h exp=37", if1.bits);
    end
    if1.load = 1'b0;
    tick();
    checks++;
    if (if1.bits !== 8'h37) begin
      errors++;
      $display("FAIL edge_ld_hold got=%h exp=37", if1.bits);
    end
    if1.x = 1'b0;
  endtask

  task automatic test_load_clamp();
    if0.load = 1'b1; if0.d = 8'hF3;
    if0.x = 1'b1; if0.dir = 1'b1;
    tick();
    checks++;
    if (if0.bits !== 8'h93 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL clamp got=%h q=%b exp=93 q=0",
               if0.bits, if0.q);
    end
    if0.load = 1'b0;
    tick();
    checks++;
    if (if0.bits !== 8'h94) begin
      errors++;
      $display("FAIL clamp_next got=%h exp=94", if0.bits);
    end
    if0.load = 1'b1; if0.d = 8'h99;
    tick();
    tick();
    checks++;
    if (if0.bits !== 8'h99 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL load_noq got=%h q=%b exp=99 q=0",
               if0.bits, if0.q);
    end
    if0.load = 1'b0; if0.x = 1'b0;
  endtask

  task automatic test_reset_mid();
    if0.load = 1'b1; if0.d = 8'h56;
    if0.x = 1'b1; if0.dir = 1'b1;
    tick();
    if0.load = 1'b0;
    tick();
    checks++;
    if (if0.bits !== 8'h57) begin
      errors++;
      $display("FAIL mid_57 got=%h exp=57", if0.bits);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (if0.bits !== 8'h00 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got=%h q=%b exp=00 q=0",
               if0.bits, if0.q);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (if0.bits !== 8'h01) begin
      errors++;
      $display("FAIL mid_resume got=%h exp=01", if0.bits);
    end
    if0.load = 1'b1; if0.d = 8'h99;
    tick();
    if0.load = 1'b0;
    tick();
    checks++;
    if (if0.bits !== 8'h00 || if0.q !== 1'b1) begin
      errors++;
      $display("FAIL q_cyc got=%h q=%b exp=00 q=1",
               if0.bits, if0.q);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (if0.bits !== 8'h00 || if0.q !== 1'b0) begin
      errors++;
      $display("FAIL q_rst got=%h q=%b exp=00 q=0",
               if0.bits, if0.q);
    end
    reset = 1'b1; if0.x = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b0;
    if0.x = 1'b0; if0.dir = 1'b1;
    if0.load = 1'b0; if0.d = '0;
    if1.x = 1'b0; if1.dir = 1'b1;
    if1.load = 1'b0; if1.d = '0;
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_edge();
    test_load_clamp();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
